// File: rtl/fu_iter.sv
// rtl/fu_iter.sv - execute unit: single-cycle RV ALU ops, iterative XLEN-cycle M-extension mul/div
module fu_iter #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [4:0]      op_i,
    input  logic [XLEN-1:0] operand1_i,
    input  logic [XLEN-1:0] operand2_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    localparam int W2 = 2 * XLEN;

    localparam logic [4:0] OP_NOP    = 5'd0;
    localparam logic [4:0] OP_ADD    = 5'd1;
    localparam logic [4:0] OP_SUB    = 5'd2;
    localparam logic [4:0] OP_XOR    = 5'd3;
    localparam logic [4:0] OP_OR     = 5'd4;
    localparam logic [4:0] OP_AND    = 5'd5;
    localparam logic [4:0] OP_SLL    = 5'd6;
    localparam logic [4:0] OP_SRL    = 5'd7;
    localparam logic [4:0] OP_SRA    = 5'd8;
    localparam logic [4:0] OP_SLT    = 5'd9;
    localparam logic [4:0] OP_SLTU   = 5'd10;
    localparam logic [4:0] OP_MUL    = 5'd11;
    localparam logic [4:0] OP_MULH   = 5'd12;
    localparam logic [4:0] OP_MULHSU = 5'd13;
    localparam logic [4:0] OP_MULHU  = 5'd14;
    localparam logic [4:0] OP_DIV    = 5'd15;
    localparam logic [4:0] OP_DIVU   = 5'd16;
    localparam logic [4:0] OP_REM    = 5'd17;
    localparam logic [4:0] OP_REMU   = 5'd18;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q,  state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      op_q,     op_d;
    // Multiply: acc = running product, mcand = shifted multiplicand, mplier = remaining multiplier bits.
    // Divide:   acc = partial remainder, mcand = divisor, mplier = dividend shifting out / quotient shifting in.
    logic [W2-1:0]   acc_q,    acc_d;
    logic [W2-1:0]   mcand_q,  mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic            neg_q,    neg_d;
    logic            div0_q,   div0_d;
    logic [SHW-1:0]  cnt_q,    cnt_d;

    logic            accept;
    logic            is_mul_op;
    logic            is_div_op;
    logic            sgn1;
    logic            sgn2;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;

    logic [W2-1:0]   mul_acc_nxt;
    logic [W2-1:0]   mul_prod;
    logic [XLEN:0]   rem_sh;
    logic [XLEN+1:0] div_diff;
    logic            div_ge;
    logic [XLEN:0]   rem_nxt;
    logic [XLEN-1:0] quo_nxt;
    logic [XLEN-1:0] quo_fin;
    logic [XLEN-1:0] rem_fin;
    logic            op_q_is_mul;
    logic            calc_last;

    assign in_ready_o  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready_i);
    assign accept      = in_valid_i && in_ready_o && !flush_i;
    assign out_valid_o = (state_q == S_DONE);
    assign busy_o      = (state_q == S_CALC);
    assign result_o    = result_q;

    // Single-cycle ALU result from the live request operands
    always_comb begin
        shamt   = operand2_i[SHW-1:0];
        alu_res = '0;
        case (op_i)
            OP_NOP:  alu_res = '0;
            OP_ADD:  alu_res = operand1_i + operand2_i;
            OP_SUB:  alu_res = operand1_i - operand2_i;
            OP_XOR:  alu_res = operand1_i ^ operand2_i;
            OP_OR:   alu_res = operand1_i | operand2_i;
            OP_AND:  alu_res = operand1_i & operand2_i;
            OP_SLL:  alu_res = operand1_i << shamt;
            OP_SRL:  alu_res = operand1_i >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(operand1_i) >>> shamt);
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(operand1_i) < $signed(operand2_i))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (operand1_i < operand2_i)};
            default: alu_res = '0;
        endcase
    end

    // Operand magnitudes and sign flags for the iterative ops
    always_comb begin
        is_mul_op = (op_i >= OP_MUL) && (op_i <= OP_MULHU);
        is_div_op = (op_i >= OP_DIV) && (op_i <= OP_REMU);
        sgn1 = operand1_i[XLEN-1] &&
               ((op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM));
        sgn2 = operand2_i[XLEN-1] &&
               ((op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM));
        mag1 = sgn1 ? ('0 - operand1_i) : operand1_i;
        mag2 = sgn2 ? ('0 - operand2_i) : operand2_i;
    end

    // One shift-add or restoring-division step, plus sign fix-up of the final step
    always_comb begin
        mul_acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
        mul_prod    = neg_q ? ('0 - mul_acc_nxt) : mul_acc_nxt;

        rem_sh   = {acc_q[XLEN-1:0], mplier_q[XLEN-1]};
        div_diff = {1'b0, rem_sh} - {2'b00, mcand_q[XLEN-1:0]};
        div_ge   = !div_diff[XLEN+1];
        rem_nxt  = div_ge ? div_diff[XLEN:0] : rem_sh;
        quo_nxt  = {mplier_q[XLEN-2:0], div_ge};
        // Divide-by-zero forces an all-ones quotient; the remainder naturally ends up as operand1.
        quo_fin  = div0_q ? '1 : (neg_q ? ('0 - quo_nxt) : quo_nxt);
        rem_fin  = neg_q ? ('0 - rem_nxt[XLEN-1:0]) : rem_nxt[XLEN-1:0];

        op_q_is_mul = (op_q <= OP_MULHU);
        calc_last   = (cnt_q == SHW'(XLEN - 1));
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        op_d     = op_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        div0_d   = div0_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_CALC: begin
                cnt_d = cnt_q + SHW'(1);
                if (op_q_is_mul) begin
                    acc_d    = mul_acc_nxt;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end else begin
                    acc_d    = {{(W2-XLEN-1){1'b0}}, rem_nxt};
                    mplier_d = quo_nxt;
                end
                if (calc_last) begin
                    state_d = S_DONE;
                    case (op_q)
                        OP_MUL:                     result_d = mul_prod[XLEN-1:0];
                        OP_MULH, OP_MULHSU, OP_MULHU: result_d = mul_prod[W2-1:XLEN];
                        OP_DIV, OP_DIVU:            result_d = quo_fin;
                        default:                    result_d = rem_fin;
                    endcase
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase

        // A new request overrides the DONE->IDLE step, giving back-to-back issue without a bubble.
        if (accept) begin
            op_d  = op_i;
            cnt_d = '0;
            if (is_mul_op) begin
                acc_d    = '0;
                mcand_d  = {{XLEN{1'b0}}, mag1};
                mplier_d = mag2;
                neg_d    = sgn1 ^ sgn2;
                div0_d   = 1'b0;
                state_d  = S_CALC;
            end else if (is_div_op) begin
                acc_d    = '0;
                mcand_d  = {{XLEN{1'b0}}, mag2};
                mplier_d = mag1;
                neg_d    = ((op_i == OP_REM) || (op_i == OP_REMU)) ? sgn1 : (sgn1 ^ sgn2);
                div0_d   = (operand2_i == '0);
                state_d  = S_CALC;
            end else begin
                result_d = alu_res;
                state_d  = S_DONE;
            end
        end

        if (flush_i) begin
            state_d = S_IDLE;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            op_q     <= OP_NOP;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            div0_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            div0_q   <= div0_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
